mips_mc_ctrl: RTL

- Multicycle MIPS main control FSM, directly upstream of the ALU control decoder.
- Decodes the instruction opcode over several states and drives the datapath enables/muxes.
- Produces the 2-bit ALUOp consumed by the ALU control decoder: 00 = add, 01 = subtract/compare, 10 = R-type funct decode.
- Adds a memory ready handshake and an optional wait timeout.

---
 rtl/mips_mc_ctrl_pkg.sv | 72 +++++++
 rtl/mips_mc_ctrl_if.sv | 40 ++++
 rtl/mips_mc_ctrl_wait_timer.sv | 35 +++
 rtl/mips_mc_ctrl.sv | 156 +++++++++++++++
 4 files changed

// File: rtl/mips_mc_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS main control FSM.
// Latency: n/a (constants, types and a helper only).
// Backpressure: n/a.
package mips_mc_ctrl_pkg;

  // Opcodes (instr[31:26]) and the JR funct code (instr[5:0])
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] FUNCT_JR = 6'h08;

  // ALUOp codes consumed by the ALU control decoder
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE = 2'b10;

  // ALUSrcB mux select
  localparam logic [1:0] SRCB_B       = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  // PCSource mux select
  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;
  localparam logic [1:0] PCSRC_JR     = 2'b11;

  typedef enum logic [3:0] {
    S_RESET  = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_MEMADR = 4'd3,
    S_MEMRD  = 4'd4,
    S_MEMWB  = 4'd5,
    S_MEMWR  = 4'd6,
    S_RTYPE  = 4'd7,
    S_ALUWB  = 4'd8,
    S_BRANCH = 4'd9,
    S_ADDI   = 4'd10,
    S_ADDIWB = 4'd11,
    S_JUMP   = 4'd12,
    S_JR     = 4'd13
  } state_t;

  // Datapath control word, decoded from state each cycle
  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
  } ctrl_t;

  // States that hold a memory access open until mem_ready
  function automatic logic is_mem_state(input state_t s);
    return (s == S_FETCH) || (s == S_MEMRD) || (s == S_MEMWR);
  endfunction

endpackage

// File: rtl/mips_mc_ctrl_if.sv
// Control/status bundle between the main control FSM and the datapath.
// Latency: n/a (wires only).
// Backpressure: memory stalls signalled through mem_ready.
// master = control FSM (drives strobes/muxes), slave = datapath side.
interface mips_mc_ctrl_if;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic       zero;
  logic       mem_ready;
  logic       PCWrite;
  logic       PCWriteCond;
  logic       IorD;
  logic       MemRead;
  logic       MemWrite;
  logic       IRWrite;
  logic       MemtoReg;
  logic       RegDst;
  logic       RegWrite;
  logic       ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [1:0] ALUOp;
  logic [1:0] PCSource;
  logic       illegal_op;
  logic       bus_err;
  logic [3:0] state_o;

  modport master (
    input  opcode, funct, zero, mem_ready,
    output PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
           MemtoReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource,
           illegal_op, bus_err, state_o
  );

  modport slave (
    output opcode, funct, zero, mem_ready,
    input  PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
           MemtoReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource,
           illegal_op, bus_err, state_o
  );
endinterface

// File: rtl/mips_mc_ctrl_wait_timer.sv
// Memory wait counter with optional timeout compare.
// Latency: timeout is combinational from the registered count and mem_ready.
// Backpressure: counts cycles the memory holds mem_ready low; saturates.
// Ports: clr (restart count), active (in a memory state), mem_ready, timeout.
module mc_wait_timer #(
  parameter int MEM_TIMEOUT = 0,  // 0 disables the timeout; must be < 2^CNT_W
  parameter int CNT_W       = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic active,
  input  logic mem_ready,
  output logic timeout
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] LIMIT   = CNT_W'(MEM_TIMEOUT);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (active && !mem_ready && (cnt != CNT_MAX)) begin
      cnt <= cnt + 1'b1;
    end
  end

  // A ready arriving on the limit cycle wins over the timeout
  assign timeout = (MEM_TIMEOUT != 0) && active && !mem_ready && (cnt == LIMIT);

endmodule

// File: rtl/mips_mc_ctrl.sv
// Multicycle MIPS main control FSM with memory ready handshake and timeout.
// Latency: lw 5, sw/R-type/addi 4, beq/bne/j/jr 3 cycles at zero wait states.
// Backpressure: FETCH/MEMRD/MEMWR hold until mem_ready or timeout (bus_err).
// Ports: clk, rst_n (async, active low), bus (master side of mips_mc_ctrl_if).
module mips_mc_ctrl
  import mips_mc_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 0,
  parameter int CNT_W       = 8
) (
  input logic            clk,
  input logic            rst_n,
  mips_mc_ctrl_if.master bus
);

  state_t state;
  state_t state_nxt;
  logic   timeout;
  logic   illegal;
  logic   in_mem;
  logic   wait_clr;
  ctrl_t  c;

  assign in_mem = is_mem_state(state);
  // Restart the wait count on every entry into a memory state, including
  // FETCH re-entering itself after a timeout.
  assign wait_clr = is_mem_state(state_nxt) && ((state_nxt != state) || timeout);

  mc_wait_timer #(
    .MEM_TIMEOUT(MEM_TIMEOUT),
    .CNT_W      (CNT_W)
  ) u_wait (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (wait_clr),
    .active   (in_mem),
    .mem_ready(bus.mem_ready),
    .timeout  (timeout)
  );

  // Next-state logic
  always_comb begin
    state_nxt = state;
    illegal   = 1'b0;
    case (state)
      S_RESET:  state_nxt = S_FETCH;
      S_FETCH:  if (bus.mem_ready) state_nxt = S_DECODE;
      S_DECODE: begin
        case (bus.opcode)
          OP_LW, OP_SW:    state_nxt = S_MEMADR;
          OP_RTYPE:        state_nxt = (bus.funct == FUNCT_JR) ? S_JR : S_RTYPE;
          OP_BEQ, OP_BNE:  state_nxt = S_BRANCH;
          OP_ADDI:         state_nxt = S_ADDI;
          OP_J:            state_nxt = S_JUMP;
          default: begin
            state_nxt = S_FETCH;
            illegal   = 1'b1;
          end
        endcase
      end
      S_MEMADR: state_nxt = (bus.opcode == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD: begin
        if (bus.mem_ready)  state_nxt = S_MEMWB;
        else if (timeout)   state_nxt = S_FETCH;
      end
      S_MEMWR:  if (bus.mem_ready || timeout) state_nxt = S_FETCH;
      S_RTYPE:  state_nxt = S_ALUWB;
      S_ADDI:   state_nxt = S_ADDIWB;
      default:  state_nxt = S_FETCH;  // write-back, branch, jump states
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_RESET;
    else        state <= state_nxt;
  end

  // Output decode from the registered state; only the fetch strobes and the
  // branch enable look at live inputs.
  always_comb begin
    c = '0;
    case (state)
      S_FETCH: begin
        c.mem_read  = 1'b1;
        c.alu_src_b = SRCB_FOUR;
        c.alu_op    = ALUOP_ADD;
        c.pc_source = PCSRC_ALU;
        c.ir_write  = bus.mem_ready;
        c.pc_write  = bus.mem_ready;
      end
      S_DECODE: c.alu_src_b = SRCB_IMM_SH2;
      S_MEMADR, S_ADDI: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = SRCB_IMM;
        c.alu_op    = ALUOP_ADD;
      end
      S_MEMRD: begin
        c.mem_read = 1'b1;
        c.iord     = 1'b1;
      end
      S_MEMWB: begin
        c.reg_write  = 1'b1;
        c.mem_to_reg = 1'b1;
      end
      S_MEMWR: begin
        c.mem_write = 1'b1;
        c.iord      = 1'b1;
      end
      S_RTYPE: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = SRCB_B;
        c.alu_op    = ALUOP_RTYPE;
      end
      S_ALUWB: begin
        c.reg_write = 1'b1;
        c.reg_dst   = 1'b1;
      end
      S_BRANCH: begin
        c.alu_src_a     = 1'b1;
        c.alu_src_b     = SRCB_B;
        c.alu_op        = ALUOP_SUB;
        c.pc_source     = PCSRC_ALUOUT;
        // beq takes on zero, bne on not-zero
        c.pc_write_cond = (bus.opcode == OP_BEQ) ? bus.zero : ~bus.zero;
      end
      S_ADDIWB: c.reg_write = 1'b1;
      S_JUMP: begin
        c.pc_write  = 1'b1;
        c.pc_source = PCSRC_JUMP;
      end
      S_JR: begin
        c.pc_write  = 1'b1;
        c.pc_source = PCSRC_JR;
      end
      default: c = '0;
    endcase
  end

  assign bus.PCWrite     = c.pc_write;
  assign bus.PCWriteCond = c.pc_write_cond;
  assign bus.IorD        = c.iord;
  assign bus.MemRead     = c.mem_read;
  assign bus.MemWrite    = c.mem_write;
  assign bus.IRWrite     = c.ir_write;
  assign bus.MemtoReg    = c.mem_to_reg;
  assign bus.RegDst      = c.reg_dst;
  assign bus.RegWrite    = c.reg_write;
  assign bus.ALUSrcA     = c.alu_src_a;
  assign bus.ALUSrcB     = c.alu_src_b;
  assign bus.ALUOp       = c.alu_op;
  assign bus.PCSource    = c.pc_source;
  assign bus.illegal_op  = illegal;
  assign bus.bus_err     = timeout;
  assign bus.state_o     = state;

endmodule
